// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and execution-unit state encoding.
// Imported by the execution unit and the ALU control decoder.
package alu_ctrl_pkg;

   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ADD = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      HOLD    = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier with start/done handshake.
// Optional early termination when ALU_MUL_EARLY_TERM_EN is defined.
module alu_seq_mul #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] step_acc;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             last;
   logic             load_busy;

   assign step_acc = acc + (mplr[0] ? mcand : '0);

`ifdef ALU_MUL_EARLY_TERM_EN
   // Stop once no set multiplier bits remain beyond the one consumed this step;
   // a zero multiplier finishes on the accept edge itself.
   assign last      = (cnt == CNT_W'(WIDTH - 1)) || (mplr[WIDTH-1:1] == '0);
   assign done      = (busy && last) || (start && (b == '0));
   assign product   = start ? '0 : step_acc;
   assign load_busy = (b != '0);
`else
   assign last      = (cnt == CNT_W'(WIDTH - 1));
   assign done      = busy && last;
   assign product   = step_acc;
   assign load_busy = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         mcand <= a;
         mplr  <= b;
         acc   <= '0;
         cnt   <= '0;
         busy  <= load_busy;
      end else if (busy) begin
         acc   <= step_acc;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         cnt   <= cnt + 1'b1;
         if (last) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/add/sub, iterative MUL, valid/ready on both sides.
// Build option ALU_MUL_EARLY_TERM_EN shortens MUL latency for small multipliers.
module alu_exec_unit
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             result_valid_o,
   input  logic             result_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   // state   | meaning
   // IDLE    | ready for a new operation
   // MUL_RUN | shift-add multiply in progress, upstream stalled
   // HOLD    | result presented until downstream accepts it

   state_t           state, state_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic [WIDTH-1:0] single_res;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   alu_seq_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .start   (mul_start),
      .a       (data1_i),
      .b       (data2_i),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      single_res = '0;
      case (ALUCtrl_i)
         ALU_OR:  single_res = data1_i | data2_i;
         ALU_AND: single_res = data1_i & data2_i;
         ALU_ADD: single_res = data1_i + data2_i;
         ALU_SUB: single_res = data1_i + ~data2_i + WIDTH'(1);
         default: single_res = '0;
      endcase
   end

   always_comb begin
      state_nxt      = state;
      res_nxt        = result_o;
      mul_start      = 1'b0;
      ready_o        = (state == IDLE);
      result_valid_o = (state == HOLD);
      case (state)
         IDLE: begin
            if (valid_i) begin
               if (ALUCtrl_i == ALU_MUL) begin
                  mul_start = 1'b1;
                  if (mul_done) begin
                     res_nxt   = mul_product;
                     state_nxt = HOLD;
                  end else begin
                     state_nxt = MUL_RUN;
                  end
               end else begin
                  res_nxt   = single_res;
                  state_nxt = HOLD;
               end
            end
         end
         MUL_RUN: begin
            if (mul_done) begin
               res_nxt   = mul_product;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (result_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         result_o <= '0;
      end else begin
         state    <= state_nxt;
         result_o <= res_nxt;
      end
   end

   assign zero_o = (result_o == '0);

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Performs AND/OR/ADD/SUB in one cycle and MUL with an iterative shift-add datapath.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits in the EX stage of the CPU and stalls upstream via ready_o while a multiply is in progress.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, width of the multiply iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  operands and control code valid.
- ready_o  out  1  unit can accept an operation.
- ALUCtrl_i  in  3  operation code (encoding below).
- data1_i  in  WIDTH  operand A (multiplicand for MUL).
- data2_i  in  WIDTH  operand B (multiplier for MUL).
- result_valid_o  out  1  result_o holds a valid result.
- result_ready_i  in  1  downstream accepts the result.
- result_o  out  WIDTH  result value.
- zero_o  out  1  high when result_o == 0; valid only while result_valid_o is high.

Behaviour:
- Encoding (ALUCtrl_i):
  - 000 NOP, result 0
  - 001 OR
  - 010 AND
  - 011 ADD
  - 100 SUB (A-B)
  - 101 MUL (low WIDTH bits of A*B)
  - 110 and 111 are treated as NOP.
- Reset (rst_i low, asynchronous):
  - State goes to IDLE.
  - ready_o=1, result_valid_o=0, result_o=0, zero_o=1, counter=0.
- State IDLE:
  - ready_o=1.
  - On valid_i && ready_o with a non-MUL code: result_o is registered at that edge; next state HOLD. Latency is 1 cycle from accept to result_valid_o.
  - On accept with MUL: latch A into the multiplicand register, B into the multiplier register, clear the accumulator, counter=0; next state MUL_RUN.
- State MUL_RUN:
  - ready_o=0.
  - Each cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - After WIDTH iterations (counter reaches WIDTH-1 on the final step), load result_o=acc and go to HOLD.
  - Fixed latency is WIDTH+1 cycles from accept to result_valid_o (33 at default).
- State HOLD:
  - result_valid_o=1, ready_o=0.
  - result_o and zero_o are held stable until result_ready_i is sampled high, then go to IDLE.
  - Holding result_ready_i high constantly gives a throughput of one op per 2 cycles (non-MUL).
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH; carries and overflow are discarded.
  - SUB is A + ~B + 1.
  - The MUL result is identical for signed and unsigned interpretation of the low WIDTH bits.
- valid_i while ready_o=0 is ignored; the operation is not queued. Upstream holds it until accepted.
- Inputs are sampled only at the accept edge. Changes to data1_i, data2_i or ALUCtrl_i during MUL_RUN have no effect.
- Reset asserted mid-MUL_RUN or mid-HOLD aborts the operation; no result is produced.
- Unknown codes (110/111) complete as NOP: result 0, zero_o=1.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- Defined: in MUL_RUN, if the remaining multiplier == 0 at the start of a cycle, the unit moves to HOLD that edge with result_o=acc. Latency is (index of the highest set bit of B)+2 cycles; B=0 gives 1 cycle.
- Undefined: fixed WIDTH+1 latency regardless of operand values.
- Results are bit-identical in both builds.

Decomposition:
- Package alu_ctrl_pkg:
  - 3-bit code constants ALU_NOP, ALU_OR, ALU_AND, ALU_ADD, ALU_SUB, ALU_MUL.
  - State encoding IDLE/MUL_RUN/HOLD.
  - The ALU control decoder imports the same constants, so the encodings cannot drift.
- One sub-module, alu_seq_mul:
  - Contains the shift-add datapath and counter.
  - Handshake: start/done.
  - Contains the early-termination logic under the macro.
- The top level keeps the FSM, the single-cycle ops and the result register.

Test Plan:
- Reset mid-MUL: start MUL 7*9, drop rst_i at cycle 5 -> immediately ready_o=1, result_valid_o=0, result_o=0, zero_o=1; no result appears afterwards.
- ADD then SUB with result_ready_i=1:
  - ADD A=0xFFFFFFFF, B=1 -> next cycle result_o=0, zero_o=1.
  - SUB A=3, B=5 -> result_o=0xFFFFFFFE, zero_o=0.
- MUL A=0x12345678, B=0x10 -> result_valid_o exactly 33 cycles after accept (default build), result_o=0x23456780. valid_i pulses during MUL_RUN are ignored and ready_o stays 0.
- Result backpressure: OR A=0xF0, B=0x0F with result_ready_i=0 for 4 cycles -> result_o=0xFF stays stable, ready_o=0 throughout; IDLE one cycle after result_ready_i=1.
- Code 111 with A=5, B=6 -> result_o=0, zero_o=1. AND A=0xFF00, B=0x0FF0 -> result_o=0x0F00.
- With ALU_MUL_EARLY_TERM_EN: MUL A=6, B=3 -> result 18 after 3 cycles; MUL A=6, B=0 -> result 0 after 1 cycle.
